nanci_commit: RTL

//  Per-PE write-commit stage, directly downstream of the mesh sort network.

---
 rtl/nanci_pkg.sv | 29 ++
 rtl/nanci_phase_counter.sv | 29 ++
 rtl/nanci_commit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/nanci_pkg.sv
// Shared types and defaults for the nanci mesh and its per-PE commit stage.
// Holds the commit FSM encoding, the {addr,data} packet layout and a sizing
// helper for the settle counter.
package nanci_pkg;

  // Default packet geometry for a 4-PE mesh.
  localparam int NANCI_ADDR_WIDTH = 2;
  localparam int NANCI_DATA_WIDTH = 2;

  // Commit FSM states. The encoding is exported on the debug state port.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCEPT = 2'd2,
    DONE   = 2'd3
  } commit_state_t;

  // One packet as it leaves the sort network.
  typedef struct packed {
    logic [NANCI_ADDR_WIDTH-1:0] addr;
    logic [NANCI_DATA_WIDTH-1:0] data;
  } packet_t;

  // Bits needed to hold the values 0..n-1. Always at least one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nanci_phase_counter.sv
// Loadable down-counter used to time the mesh settle window.
// load has priority over dec; the count holds at zero instead of wrapping.
// The upstream injector uses the same block with its own load value.
module nanci_phase_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  // Count register: reload, otherwise step down toward zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/nanci_commit.sv
// Per-PE write-commit stage, downstream of the mesh sort network.
// After phase_start the stage waits SORT_CYCLES cycles for the mesh to settle,
// then accepts packets: those addressed to PE_ID are written into the local
// memory word, anything else raises the sticky err_misroute flag. A beat with
// in_last ends the phase and done pulses for one cycle.
//
// Optional feature: define NANCI_COMMIT_CONFLICT_DETECT_EN to add the sticky
// conflict output, set when a second write to PE_ID lands in one phase.
//
// Handshake: a beat transfers on a rising edge where in_valid and in_ready
// are both 1. in_ready depends only on the state register (never on
// in_valid), and in_addr/in_data/in_last are only looked at on a transfer.
module nanci_commit
  import nanci_pkg::*;
#(
  parameter int ADDR_WIDTH  = NANCI_ADDR_WIDTH,
  parameter int DATA_WIDTH  = NANCI_DATA_WIDTH,
  parameter int SORT_CYCLES = 4,
  parameter int PE_ID       = 0,
  parameter int MEM_INIT    = 0,
  parameter int CNT_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  phase_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] memory,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  err_misroute,
`ifdef NANCI_COMMIT_CONFLICT_DETECT_EN
  output logic                  conflict,
`endif
  output logic                  done,
  output logic [1:0]            fsm_state
);

  localparam int                    SCW         = cnt_bits(SORT_CYCLES);
  localparam logic [SCW-1:0]        SETTLE_LOAD = SCW'(SORT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] PE_ADDR     = ADDR_WIDTH'(PE_ID);
  localparam logic [DATA_WIDTH-1:0] MEM_RESET   = DATA_WIDTH'(MEM_INIT);

  commit_state_t  state_q;
  commit_state_t  state_d;
  logic           clear_phase;
  logic           cnt_load;
  logic           cnt_dec;
  logic           cnt_zero;
  logic [SCW-1:0] cnt_value;
  logic           fire;
  logic           hit;
  logic           cnt_full;

  // Settle window timer: loaded with SORT_CYCLES-1 on phase start so that
  // ACCEPT is entered exactly SORT_CYCLES edges after phase_start is sampled.
  nanci_phase_counter #(
    .WIDTH (SCW)
  ) u_settle_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value (SETTLE_LOAD),
    .dec        (cnt_dec),
    .count      (cnt_value),
    .zero       (cnt_zero)
  );

  // Handshake and hit decode. Only ACCEPT takes beats, so SETTLE ignores
  // in_valid and no write can happen outside ACCEPT.
  assign in_ready  = (state_q == ACCEPT);
  assign done      = (state_q == DONE);
  assign fire      = in_valid && in_ready;
  assign hit       = fire && (in_addr == PE_ADDR);
  assign cnt_full  = (wr_count == {CNT_WIDTH{1'b1}});
  assign fsm_state = state_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and phase-control decode. phase_start is honoured only from
  // IDLE or DONE; in SETTLE and ACCEPT the running phase carries on.
  always_comb begin
    state_d     = state_q;
    clear_phase = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (phase_start) begin
          state_d     = SETTLE;
          clear_phase = 1'b1;
          cnt_load    = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_zero) begin
          state_d = ACCEPT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ACCEPT: begin
        if (fire && in_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (phase_start) begin
          state_d     = SETTLE;
          clear_phase = 1'b1;
          cnt_load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Local memory word: the last accepted write to this PE wins. It is not
  // cleared at phase start, only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      memory <= MEM_RESET;
    end else if (hit) begin
      memory <= in_data;
    end
  end

  // Per-phase write count, saturating at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (clear_phase) begin
      wr_count <= '0;
    end else if (hit && !cnt_full) begin
      wr_count <= wr_count + 1'b1;
    end
  end

  // Sticky misroute flag: any accepted beat not addressed to this PE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_misroute <= 1'b0;
    end else if (clear_phase) begin
      err_misroute <= 1'b0;
    end else if (fire && !hit) begin
      err_misroute <= 1'b1;
    end
  end

`ifdef NANCI_COMMIT_CONFLICT_DETECT_EN
  // Sticky write conflict: a hit while wr_count is already non-zero means a
  // previous write to this PE was taken in the same phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict <= 1'b0;
    end else if (clear_phase) begin
      conflict <= 1'b0;
    end else if (hit && (wr_count != '0)) begin
      conflict <= 1'b1;
    end
  end
`endif

endmodule
